// File: rtl/branch_pc_unit_if.sv
// Fetch-redirect bus between the execute-stage branch resolver and the fetch PC unit.
interface branch_pc_unit_if #(
   parameter int unsigned PC_W = 10
);
   logic            stall;
   logic            br_valid;
   logic            br_cond;
   logic            jmp;
   logic [PC_W-1:0] br_pc;
   logic [PC_W-1:0] br_offset;
   logic [PC_W-1:0] jmp_target;
   logic [PC_W-1:0] pc;
   logic            flush;
   logic            redirect;
   logic [15:0]     taken_cnt;

   modport master (
      output stall, br_valid, br_cond, jmp, br_pc, br_offset, jmp_target,
      input  pc, flush, redirect, taken_cnt
   );

   modport slave (
      input  stall, br_valid, br_cond, jmp, br_pc, br_offset, jmp_target,
      output pc, flush, redirect, taken_cnt
   );
endinterface

// File: rtl/branch_pc_unit.sv
// Fetch PC register with branch/jump redirect, a timed flush window and a saturating taken counter.
module branch_pc_unit #(
   parameter int unsigned PC_W         = 10,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   branch_pc_unit_if.slave  bus
);
   localparam logic [1:0]       FCNT_INIT = 2'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {
      S_RUN,
      S_FLUSH
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       fcnt_q, fcnt_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             flush_q, flush_d;
   logic             redirect_q, redirect_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             taken;
   logic [PC_W-1:0]  target;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RUN;
         fcnt_q     <= 2'd0;
         pc_q       <= '0;
         flush_q    <= 1'b0;
         redirect_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         pc_q       <= pc_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         cnt_q      <= cnt_d;
      end
   end

   // Branches arriving while the pipe is being squashed belong to wrong-path code.
   always_comb begin
      state_d    = state_q;
      fcnt_d     = fcnt_q;
      pc_d       = pc_q;
      flush_d    = 1'b0;
      redirect_d = 1'b0;
      cnt_d      = cnt_q;
      taken      = (state_q == S_RUN) && bus.br_valid && (bus.jmp || bus.br_cond);
      target     = bus.jmp ? bus.jmp_target
                           : bus.br_pc + PC_W'(1) + bus.br_offset;

      unique case (state_q)
         S_RUN: begin
            if (taken) begin
               pc_d       = target;
               redirect_d = 1'b1;
               flush_d    = 1'b1;
               fcnt_d     = FCNT_INIT;
               state_d    = S_FLUSH;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end else if (!bus.stall) begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         S_FLUSH: begin
            if (!bus.stall) pc_d = pc_q + PC_W'(1);
            if (fcnt_q == 2'd0) begin
               state_d = S_RUN;
            end else begin
               flush_d = 1'b1;
               fcnt_d  = fcnt_q - 2'd1;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   assign bus.pc        = pc_q;
   assign bus.flush     = flush_q;
   assign bus.redirect  = redirect_q;
   assign bus.taken_cnt = 16'(cnt_q);

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter: PC_W, default 10, program-counter width in bits.
REQ-002 Parameter: FLUSH_CYCLES, default 2, number of cycles flush is held after a redirect; legal range 1-3.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: stall  input  1  hold PC; fetch stage not accepting.
REQ-006 Port: br_valid  input  1  branch/jump instruction present in execute this cycle.
REQ-007 Port: br_cond  input  1  equality-comparator result for the branch (1 = condition met).
REQ-008 Port: jmp  input  1  unconditional jump; meaningful only with br_valid.
REQ-009 Port: br_pc  input  PC_W  PC of the branch instruction.
REQ-010 Port: br_offset  input  PC_W  two's-complement relative offset for conditional branches.
REQ-011 Port: jmp_target  input  PC_W  absolute target for jumps.
REQ-012 Port: pc  output  PC_W  registered fetch address.
REQ-013 Port: flush  output  1  registered; squash fetch/decode contents.
REQ-014 Port: redirect  output  1  registered one-cycle pulse; pc loaded from a target this cycle.
REQ-015 Port: taken_cnt  output  16  saturating count of taken branches/jumps.

Function
REQ-016 taken = br_valid & (jmp | br_cond), evaluated only in state RUN; br_valid in FLUSH is ignored entirely.
REQ-017 Target: jmp=1 -> jmp_target; else br_pc + 1 + br_offset, computed modulo 2^PC_W (wrap, no overflow flag).
REQ-018 States: RUN, FLUSH; internal down-counter fcnt of 2 bits.
REQ-019 RUN, taken=1: next cycle pc=target, redirect=1, flush=1, fcnt=FLUSH_CYCLES-1, state->FLUSH; stall does not block redirect.
REQ-020 RUN, taken=0, stall=0: pc increments by 1, wrapping 2^PC_W-1 -> 0; flush=0, redirect=0.
REQ-021 RUN, taken=0, stall=1: pc holds; flush=0, redirect=0.
REQ-022 FLUSH: flush=1 every cycle; redirect=0 after its first cycle; if fcnt=0 -> RUN with flush=0 next cycle, else fcnt decrements.
REQ-023 FLUSH, stall=0: pc increments (fetch from target continues); stall=1: pc holds; stall does not extend the flush window.
REQ-024 FLUSH_CYCLES=1: flush high exactly one cycle (coincident with redirect).
REQ-025 taken_cnt increments by 1 on each accepted taken event; saturates at 16'hFFFF.
REQ-026 Latency: taken seen at edge N -> pc=target, redirect=1 visible after edge N; flush high for cycles N+1..N+FLUSH_CYCLES.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 rst=1 at an edge: pc=0, flush=0, redirect=0, taken_cnt=0, fcnt=0, state=RUN; overrides all other inputs.
REQ-029 rst asserted mid-FLUSH aborts the flush; first cycle after rst deasserts is RUN with pc=0.
REQ-030 rst coincident with taken: branch discarded, taken_cnt not incremented.

Verification
REQ-031 Reset then 5 cycles stall=0, br_valid=0 -> pc 0,1,2,3,4,5; flush=0; taken_cnt=0.
REQ-032 pc=20, br_valid=1, br_cond=1, jmp=0, br_pc=18, br_offset=10'h3FC (-4) -> next pc=15, redirect=1 one cycle, flush=1 for 2 cycles, taken_cnt=1.
REQ-033 br_valid=1, jmp=1, jmp_target=700, stall=1 -> next pc=700, redirect=1; second br_valid=1,br_cond=1 in following cycle (FLUSH) ignored, taken_cnt=1.
REQ-034 br_valid=1, br_cond=0, jmp=0 -> no redirect, pc increments, flush=0, taken_cnt unchanged.
REQ-035 br_pc=1022, br_offset=5, br_cond=1 -> pc=4 (wrap); free-run from pc=1023 -> pc=0.
REQ-036 rst pulsed during second flush cycle -> pc=0, flush=0, redirect=0, taken_cnt=0 next cycle; preload taken_cnt near 16'hFFFF by 65536 taken events -> holds 16'hFFFF.
